// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH shift cycles,
// one difference/borrow slice plus a borrow flip-flop, start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bin_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  logic             slice_diff;
  logic             slice_borrow;

  always_comb begin
    slice_diff   = ra_q[0] ^ rb_q[0] ^ bin_q;
    slice_borrow = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bin_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          ra_q   <= ra_q >> 1;
          rb_q   <= rb_q >> 1;
          diff_q <= {slice_diff, diff_q[WIDTH-1:1]};
          bin_q  <= slice_borrow;
          cnt_q  <= cnt_q + 1'b1;
          // The last slice's borrow is the unsigned a < b indication.
          if (cnt_q == LAST) begin
            borrow_q <= slice_borrow;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule
